// File: rtl/morse_symbol_tx.sv
// Morse symbol transmitter: sends up to four dot/dash symbols of one letter on a single LED.
// Dot = 1 unit lit, dash = 3 units lit, 1 unit dark between symbols, then a one-cycle done pulse.
module morse_symbol_tx #(
    parameter int unsigned UNIT_CYCLES = 25_000_000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [2:0] size_i,
    input  logic [3:0] pattern_i,
    output logic       led_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int unsigned CNT_W = $clog2(3 * UNIT_CYCLES + 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StOn   = 2'd1;
    localparam logic [1:0] StGap  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam logic [CNT_W-1:0] UnitLoad = CNT_W'(UNIT_CYCLES);
    localparam logic [CNT_W-1:0] DashLoad = CNT_W'(3 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] TimerOne = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [2:0]       rem_q, rem_d;
    logic [3:0]       shreg_q, shreg_d;
    logic             led_q, led_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [2:0]       size_eff;

    assign size_eff = (size_i > 3'd4) ? 3'd4 : size_i;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        rem_d   = rem_q;
        shreg_d = shreg_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    shreg_d = pattern_i;
                    rem_d   = size_eff;
                    if (size_eff == 3'd0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StOn;
                        timer_d = pattern_i[3] ? DashLoad : UnitLoad;
                    end
                end
            end
            StOn: begin
                // Timer holds the cycles left including the current one.
                if (timer_q <= TimerOne) begin
                    rem_d   = rem_q - 3'd1;
                    shreg_d = {shreg_q[2:0], 1'b0};
                    if (rem_q <= 3'd1) begin
                        state_d = StDone;
                        timer_d = '0;
                    end else begin
                        state_d = StGap;
                        timer_d = UnitLoad;
                    end
                end else begin
                    timer_d = timer_q - TimerOne;
                end
            end
            StGap: begin
                if (timer_q <= TimerOne) begin
                    state_d = StOn;
                    timer_d = shreg_q[3] ? DashLoad : UnitLoad;
                end else begin
                    timer_d = timer_q - TimerOne;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change with the state register.
    always_comb begin
        led_d  = (state_d == StOn);
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            timer_q <= '0;
            rem_q   <= '0;
            shreg_q <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            rem_q   <= rem_d;
            shreg_q <= shreg_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign led_o  = led_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_morse_symbol_tx.sv
// Self-checking bench for morse_symbol_tx: directed vector table, hand-written corner
// sequences and randomized traffic against a symbol-list reference model.
module tb_morse_symbol_tx;

    localparam int unsigned U = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] size;
    logic [3:0] pattern;
    logic       led;
    logic       busy;
    logic       done;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic led;
        logic busy;
        logic done;
    } out_t;

    typedef struct {
        logic [2:0] sz;
        logic [3:0] pat;
        int         exp_len;
        int         exp_on;
    } vec_t;

    out_t exp_q[$];
    out_t cur_exp;
    vec_t vecs[7];

    morse_symbol_tx #(
        .UNIT_CYCLES(U)
    ) dut (
        .clk_i    (clk),
        .reset_i  (reset),
        .start_i  (start),
        .size_i   (size),
        .pattern_i(pattern),
        .led_o    (led),
        .busy_o   (busy),
        .done_o   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected per-cycle outputs of one letter, starting the cycle after acceptance.
    task automatic push_letter(input logic [2:0] sz, input logic [3:0] pat);
        int n;
        int dur;
        n = (sz > 3'd4) ? 4 : int'(sz);
        for (int i = 0; i < n; i++) begin
            dur = pat[3-i] ? 3 * U : U;
            for (int c = 0; c < dur; c++) exp_q.push_back(out_t'(3'b110));
            if (i < n - 1) begin
                for (int c = 0; c < U; c++) exp_q.push_back(out_t'(3'b010));
            end
        end
        exp_q.push_back(out_t'(3'b011));
    endtask

    // Compare this cycle's outputs against the model, then drive this cycle's inputs.
    task automatic cycle(input logic st, input logic [2:0] sz, input logic [3:0] pat);
        out_t act;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
        else cur_exp = '0;
        act = {led, busy, done};
        check("model_outputs", 32'(act), 32'(cur_exp));
        start   = st;
        size    = sz;
        pattern = pat;
        if (st && !cur_exp.busy) push_letter(sz, pat);
    endtask

    // Letter 'A' with constant expected waveform; late_change alters size/pattern mid-letter.
    task automatic run_case1(input bit late_change);
        logic [2:0] sz;
        logic [3:0] pat;
        for (int k = 0; k <= 24; k++) begin
            sz  = (late_change && k >= 3) ? 3'd4 : 3'd2;
            pat = (late_change && k >= 3) ? 4'b1111 : 4'b0100;
            cycle(k == 0, sz, pat);
            check("c1_led", 32'(led), 32'((k >= 1 && k <= 4) || (k >= 9 && k <= 20)));
            check("c1_busy", 32'(busy), 32'(k >= 1 && k <= 21));
            check("c1_done", 32'(done), 32'(k == 21));
        end
    endtask

    initial begin
        int done_at;
        int n_busy;
        int n_on;
        logic st;

        vecs[0] = '{3'd2, 4'b0100, 21, 16};
        vecs[1] = '{3'd0, 4'b1111, 1, 0};
        vecs[2] = '{3'd7, 4'b1111, 61, 48};
        vecs[3] = '{3'd1, 4'b0000, 5, 4};
        vecs[4] = '{3'd3, 4'b1010, 37, 28};
        vecs[5] = '{3'd4, 4'b0000, 29, 16};
        vecs[6] = '{3'd5, 4'b0110, 45, 32};

        reset   = 1'b1;
        start   = 1'b0;
        size    = '0;
        pattern = '0;
        cur_exp = '0;
        #12;
        check("reset_led", 32'(led), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Table-driven letters: done cycle, busy length and lit-cycle count.
        for (int v = 0; v < 7; v++) begin
            done_at = -1;
            n_busy  = 0;
            n_on    = 0;
            cycle(1'b1, vecs[v].sz, vecs[v].pat);
            for (int k = 1; k <= 200 && done_at < 0; k++) begin
                cycle(1'b0, 3'd0, 4'd0);
                if (busy) n_busy++;
                if (led) n_on++;
                if (done) done_at = k;
            end
            cycle(1'b0, 3'd0, 4'd0);
            check("tbl_done_cycle", 32'(done_at), 32'(vecs[v].exp_len));
            check("tbl_busy_count", 32'(n_busy), 32'(vecs[v].exp_len));
            check("tbl_on_count", 32'(n_on), 32'(vecs[v].exp_on));
            check("tbl_done_pulse", 32'(done), 0);
            check("tbl_idle_busy", 32'(busy), 0);
        end

        run_case1(1'b0);
        run_case1(1'b1);

        // 'E' with starts while busy (cycle 2) and in the done cycle (5); start at 6 accepted.
        for (int k = 0; k <= 8; k++) begin
            st = (k == 0 || k == 2 || k == 5 || k == 6);
            cycle(st, (k == 0) ? 3'd1 : 3'd4, 4'b0000);
            if (k == 4) check("c4_led_last", 32'(led), 1);
            if (k == 5) check("c4_done", 32'(done), 1);
            if (k == 5) check("c4_led_off", 32'(led), 0);
            if (k == 6) check("c4_idle", 32'(busy), 0);
            if (k == 7) check("c4_restart_led", 32'(led), 1);
        end
        for (int k = 0; k < 100 && (exp_q.size() > 0 || busy); k++) cycle(1'b0, 3'd0, 4'd0);

        // Reset in the middle of the dash, then the same letter resent from the start.
        for (int k = 0; k <= 10; k++) cycle(k == 0, 3'd2, 4'b0100);
        check("c6_pre_reset_led", 32'(led), 1);
        reset = 1'b1;
        #1;
        check("c6_async_led", 32'(led), 0);
        check("c6_async_busy", 32'(busy), 0);
        check("c6_async_done", 32'(done), 0);
        exp_q.delete();
        start = 1'b0;
        @(posedge clk);
        #1;
        check("c6_held_done", 32'(done), 0);
        reset = 1'b0;
        run_case1(1'b0);

        // Randomized traffic with occasional asynchronous resets.
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 699) == 0) begin
                #2;
                reset = 1'b1;
                #1;
                check("rnd_reset_out", 32'({led, busy, done}), 0);
                exp_q.delete();
                start = 1'b0;
                @(posedge clk);
                #1;
                reset = 1'b0;
            end else begin
                cycle($urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)),
                      4'($urandom_range(0, 15)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
